mac_block_accumulator: RTL and testbench

- Downstream consumer of the registered multiply-add stage (DATA_OUT = A*B + C, 2-cycle latency, no valid).
- Tracks which MAC results are meaningful with its own 2-stage issue delay line.
- Sums each group of BLOCK_LEN results into one block sum.
- Hands block sums to the next stage through a 2-entry valid/ready output buffer, with a sticky overflow flag for dropped sums.

---
 rtl/mac_block_accumulator.sv | 125 ++++++++++++
 tb/tb_mac_block_accumulator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_block_accumulator.sv
// Block accumulator behind the 2-cycle multiply-add stage: tracks valid MAC results,
// sums each group of BLOCK_LEN of them, and queues block sums in a 2-entry valid/ready buffer.
package params;
  localparam int DATA_OUT_WIDTH = 16;
endpackage

module mac_block_accumulator #(
  parameter int IN_WIDTH  = params::DATA_OUT_WIDTH,
  parameter int BLOCK_LEN = 4,
  parameter int SUM_WIDTH = IN_WIDTH + $clog2(BLOCK_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue,
  input  logic [IN_WIDTH-1:0]  mac_data,
  input  logic                 clear,
  output logic [SUM_WIDTH-1:0] sum_out,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [1:0]           fill,
  output logic                 overflow,
  input  logic                 clr_ovf
);
  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  function automatic logic [SUM_WIDTH-1:0] widen(input logic [IN_WIDTH-1:0] x);
    return SUM_WIDTH'(x);
  endfunction

  logic                 vld_p1, vld_p2;
  logic [SUM_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic [SUM_WIDTH-1:0] ent0, ent1;
  logic                 accept, blk_last, push, pop, drop;
  logic [SUM_WIDTH-1:0] blk_sum;

  // Stage p1/p2: issue delay line matching the MAC's two-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      vld_p2 <= vld_p1;
    end
  end

  assign accept   = vld_p2 & ~clear;
  assign blk_last = (cnt == CNT_LAST);
  assign blk_sum  = acc + widen(mac_data);
  assign push     = accept & blk_last;

  // Stage acc: running block sum; SUM_WIDTH headroom means no wrap is possible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (blk_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= blk_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sum_valid = (fill != 2'd0);
  assign sum_out   = sum_valid ? ent0 : '0;
  assign pop       = sum_valid & sum_ready;
  assign drop      = push & (fill == 2'd2) & ~pop;

  // Stage out: 2-entry buffer, ent0 is the head; a simultaneous pop makes room for the push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      fill <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          case (fill)
            2'd0: begin
              ent0 <= blk_sum;
              fill <= 2'd1;
            end
            2'd1: begin
              ent1 <= blk_sum;
              fill <= 2'd2;
            end
            default: ;
          endcase
        end
        2'b01: begin
          ent0 <= ent1;
          ent1 <= '0;
          fill <= fill - 2'd1;
        end
        2'b11: begin
          if (fill == 2'd2) begin
            ent0 <= ent1;
            ent1 <= blk_sum;
          end else begin
            ent0 <= blk_sum;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end
endmodule

// File: tb/tb_mac_block_accumulator.sv
// Randomised and directed bench for mac_block_accumulator against a transaction-level model.
module tb_mac_block_accumulator;
  localparam int IN_W = 16;
  localparam int BL   = 4;
  localparam int SW   = 18;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            issue = 1'b0;
  logic [IN_W-1:0] mac_data = '0;
  logic            clear = 1'b0;
  logic [SW-1:0]   sum_out;
  logic            sum_valid;
  logic            sum_ready = 1'b0;
  logic [1:0]      fill;
  logic            overflow;
  logic            clr_ovf = 1'b0;

  mac_block_accumulator #(.IN_WIDTH(IN_W), .BLOCK_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .mac_data(mac_data), .clear(clear),
    .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready), .fill(fill),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int sched[int];
  int issq[$];
  int part[$];
  int expq[$];
  bit exp_ovf = 1'b0;

  // Model: an issue at edge j yields its sample at edge j+2 unless a clear lands at j..j+2.
  task automatic cycle(input bit iss, input int v, input bit clr, input bit rdy, input bit cov);
    bit acc_now, push, drop, pop;
    int s;
    issue = iss; clear = clr; sum_ready = rdy; clr_ovf = cov;
    if (iss) sched[edge_n + 2] = v;
    if (sched.exists(edge_n)) begin
      mac_data = IN_W'(sched[edge_n]);
      sched.delete(edge_n);
    end else begin
      mac_data = 16'hDEAD;
    end
    acc_now = (issq.size() > 0) && (issq[0] == edge_n - 2);
    if (acc_now) void'(issq.pop_front());
    push = 1'b0;
    s = 0;
    if (clr) begin
      issq.delete();
      part.delete();
    end else begin
      if (acc_now) begin
        part.push_back(int'(mac_data));
        if (part.size() == BL) begin
          s = part.sum();
          push = 1'b1;
          part.delete();
        end
      end
      if (iss) issq.push_back(edge_n);
    end
    pop  = (expq.size() > 0) && rdy;
    drop = push && (expq.size() == 2) && !pop;
    if (pop) void'(expq.pop_front());
    if (push && !drop) expq.push_back(s);
    if (drop) exp_ovf = 1'b1;
    else if (cov) exp_ovf = 1'b0;
    @(posedge clk); #1;
    edge_n++;
  endtask

  function automatic logic [21:0] exp_vec();
    logic [SW-1:0] h;
    h = (expq.size() > 0) ? SW'(expq[0]) : '0;
    return {expq.size() > 0, h, 2'(expq.size()), exp_ovf};
  endfunction

  function automatic void flush_model();
    issq.delete(); part.delete(); expq.delete(); exp_ovf = 1'b0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sum_valid, sum_out, fill, overflow} !== 22'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {sum_valid, sum_out, fill, overflow});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    flush_model();
  endtask

  task automatic test_basic();
    int vals[4] = '{10, 20, 30, 40};
    int first = -1, npulse = 0, last_iss = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) last_iss = edge_n;
      cycle(i < 4, vals[i % 4], 1'b0, 1'b1, 1'b0);
      checks++;
      if ({sum_valid, sum_out, fill, overflow} !== exp_vec()) begin
        failures++;
        $display("FAIL basic_cycle%0d got=%h exp=%h", i, {sum_valid, sum_out, fill, overflow}, exp_vec());
      end
      if (sum_valid) begin
        npulse++;
        if (first < 0) first = edge_n - 1;
        checks++;
        if (sum_out !== 18'd100) begin
          failures++;
          $display("FAIL basic_sum got=%0d exp=100", sum_out);
        end
      end
    end
    checks++;
    if (npulse != 1 || first != last_iss + 2) begin
      failures++;
      $display("FAIL basic_timing pulses=%0d first_edge=%0d exp_pulses=1 exp_edge=%0d", npulse, first, last_iss + 2);
    end
    checks++;
    if (fill !== 2'd0) begin
      failures++;
      $display("FAIL basic_fill got=%0d exp=0", fill);
    end
  endtask

  task automatic test_width();
    int got = -1;
    for (int i = 0; i < 9; i++) begin
      cycle(i < 4, 32'hFFFF, 1'b0, 1'b1, 1'b0);
      if (sum_valid) got = int'(sum_out);
    end
    checks++;
    if (got != 32'h3FFFC) begin
      failures++;
      $display("FAIL width_sum got=%h exp=3fffc", got);
    end
  endtask

  task automatic test_gapped();
    bit pat[7] = '{1, 0, 1, 1, 0, 0, 1};
    int k = 1, got = -1;
    for (int i = 0; i < 11; i++) begin
      if (i < 7 && pat[i]) begin
        cycle(1'b1, k, 1'b0, 1'b1, 1'b0);
        k++;
      end else begin
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if ({sum_valid, sum_out, fill, overflow} !== exp_vec()) begin
        failures++;
        $display("FAIL gapped_cycle%0d got=%h exp=%h", i, {sum_valid, sum_out, fill, overflow}, exp_vec());
      end
      if (sum_valid) got = int'(sum_out);
    end
    checks++;
    if (got != 10) begin
      failures++;
      $display("FAIL gapped_sum got=%0d exp=10", got);
    end
  endtask

  task automatic test_backpressure();
    int vals[12] = '{10, 20, 30, 40, 50, 50, 50, 50, 75, 75, 75, 75};
    int popped[$];
    for (int i = 0; i < 15; i++) cycle(i < 12, vals[i % 12], 1'b0, 1'b0, 1'b0);
    checks++;
    if (fill !== 2'd2 || sum_out !== 18'd100 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got fill=%0d sum=%0d ovf=%0d exp fill=2 sum=100 ovf=1", fill, sum_out, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      if (sum_valid) popped.push_back(int'(sum_out));
      cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({sum_valid, sum_out, fill, overflow} !== exp_vec()) begin
        failures++;
        $display("FAIL bp_drain%0d got=%h exp=%h", i, {sum_valid, sum_out, fill, overflow}, exp_vec());
      end
    end
    checks++;
    if (popped.size() != 2 || popped[0] != 100 || popped[1] != 200 || fill !== 2'd0) begin
      failures++;
      $display("FAIL bp_order got n=%0d first=%0d fill=%0d exp n=2 100,200 fill=0", popped.size(),
               (popped.size() > 0) ? popped[0] : -1, fill);
    end
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL bp_clr_ovf got=%0d exp=0", overflow);
    end
  endtask

  task automatic test_push_pop_full();
    int vals[8] = '{2, 2, 2, 2, 3, 3, 3, 3};
    int blk[4] = '{5, 10, 15, 20};
    int popped[$];
    for (int i = 0; i < 10; i++) cycle(i < 8, vals[i % 8], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(i < 4, blk[i % 4], 1'b0, 1'b0, 1'b0);
    if (sum_valid) popped.push_back(int'(sum_out));
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (fill !== 2'd2 || overflow !== 1'b0 || sum_out !== 18'd12) begin
      failures++;
      $display("FAIL ppf_state got fill=%0d ovf=%0d sum=%0d exp fill=2 ovf=0 sum=12", fill, overflow, sum_out);
    end
    for (int i = 0; i < 4; i++) begin
      if (sum_valid) popped.push_back(int'(sum_out));
      cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({sum_valid, sum_out, fill, overflow} !== exp_vec()) begin
        failures++;
        $display("FAIL ppf_drain%0d got=%h exp=%h", i, {sum_valid, sum_out, fill, overflow}, exp_vec());
      end
    end
    checks++;
    if (popped.size() != 3 || popped[0] != 8 || popped[1] != 12 || popped[2] != 50) begin
      failures++;
      $display("FAIL ppf_order got n=%0d last=%0d exp n=3 8,12,50", popped.size(),
               (popped.size() > 0) ? popped[popped.size() - 1] : -1);
    end
  endtask

  task automatic test_clear();
    int got[$];
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 6, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(i < 4, 1, 1'b0, 1'b1, 1'b0);
      if (sum_valid) got.push_back(int'(sum_out));
    end
    checks++;
    if (got.size() != 1 || got[0] != 4) begin
      failures++;
      $display("FAIL clear_partial got n=%0d v=%0d exp n=1 v=4", got.size(), (got.size() > 0) ? got[0] : -1);
    end
    got.delete();
    for (int i = 0; i < 9; i++) begin
      cycle(i < 4, 1, i == 5, 1'b1, 1'b0);
      if (sum_valid) got.push_back(int'(sum_out));
    end
    checks++;
    if (got.size() != 0) begin
      failures++;
      $display("FAIL clear_completing got n=%0d exp n=0", got.size());
    end
    for (int i = 0; i < 8; i++) begin
      cycle(i < 4, 2, 1'b0, 1'b1, 1'b0);
      if (sum_valid) got.push_back(int'(sum_out));
    end
    checks++;
    if (got.size() != 1 || got[0] != 8) begin
      failures++;
      $display("FAIL clear_after got n=%0d v=%0d exp n=1 v=8", got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int vals[4] = '{1, 2, 3, 4};
    int got[$];
    for (int i = 0; i < 6; i++) cycle(i < 4, 1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 7, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fill !== 2'd1 || sum_out !== 18'd4) begin
      failures++;
      $display("FAIL rstmid_pre got fill=%0d sum=%0d exp fill=1 sum=4", fill, sum_out);
    end
    issue = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum_valid, sum_out, fill, overflow} !== 22'h0) begin
      failures++;
      $display("FAIL rstmid_async got=%h exp=0", {sum_valid, sum_out, fill, overflow});
    end
    #2 rst_n = 1'b1;
    flush_model();
    for (int i = 0; i < 9; i++) begin
      cycle(i < 4, vals[i % 4], 1'b0, 1'b1, 1'b0);
      if (sum_valid) got.push_back(int'(sum_out));
    end
    checks++;
    if (got.size() != 1 || got[0] != 10) begin
      failures++;
      $display("FAIL rstmid_next got n=%0d v=%0d exp n=1 v=10", got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      checks++;
      if ({sum_valid, sum_out, fill, overflow} !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, {sum_valid, sum_out, fill, overflow}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width();
    test_gapped();
    test_backpressure();
    test_push_pop_full();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
